// File: rtl/btb_pkg.sv
// Package: btb_pkg
// Shared widths and the entry layout for the branch target buffer.
// Tag and counter fields are sized for the widest legal configuration
// (ENTRIES >= 2 gives at most a 29-bit tag; counters up to 8 bits). Narrower
// configurations zero-extend into these fields.
package btb_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned WORD_W      = 30;
    localparam int unsigned TAG_FIELD_W = 29;
    localparam int unsigned CTR_FIELD_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [TAG_FIELD_W-1:0] tag;
        logic [CTR_FIELD_W-1:0] ctr;
        logic [WORD_W-1:0]      target;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Module: sat_counter
// Combinational next value of a saturating up/down counter.
// Ports:
//   value      in  CTR_W  current counter value
//   up         in  1      1: increment, 0: decrement
//   next_value out CTR_W  value +/- 1, clamped to [0, 2**CTR_W-1]
module sat_counter #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] value,
    input  logic             up,
    output logic [CTR_W-1:0] next_value
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    always_comb begin
        next_value = value;
        if (up) begin
            if (value != CTR_MAX) begin
                next_value = value + 1'b1;
            end
        end else begin
            if (value != '0) begin
                next_value = value - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Module: branch_target_buffer
// Direct-mapped branch target buffer with a saturating direction counter per
// entry. Lookup is combinational; the table is written on the falling clock
// edge so an update driven after a rising edge is visible to lookups in the
// second half of the same cycle.
// Ports:
//   CLK, nRST       clock, asynchronous active-low reset
//   lookup_pc       fetch PC (bits [1:0] ignored)
//   hit             valid entry with matching tag at the lookup index
//   predict_taken   hit & counter MSB
//   target          predicted target, 0 when no hit
//   update_en       resolved branch writeback this cycle
//   update_pc       PC of the resolved branch
//   update_taken    actual outcome
//   update_target   actual target (bits [1:0] ignored)
//   flush           invalidate all entries (wins over update_en)
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            hit,
    output logic            predict_taken,
    output logic [PC_W-1:0] target,
    input  logic            update_en,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            flush
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WORD_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(2 ** (CTR_W - 1));

    btb_entry_t tbl [ENTRIES];

    logic [IDX_W-1:0]       l_idx;
    logic [TAG_FIELD_W-1:0] l_tag;
    btb_entry_t             l_entry;

    logic [IDX_W-1:0]       u_idx;
    logic [TAG_FIELD_W-1:0] u_tag;
    btb_entry_t             u_entry;
    logic                   u_hit;
    logic [CTR_W-1:0]       ctr_next;
    btb_entry_t             alloc_entry;

    // Lookup path
    assign l_idx   = lookup_pc[IDX_W+1:2];
    assign l_tag   = TAG_FIELD_W'(lookup_pc[PC_W-1:IDX_W+2]);
    assign l_entry = tbl[l_idx];

    assign hit           = l_entry.valid && (l_entry.tag == l_tag);
    assign predict_taken = hit && l_entry.ctr[CTR_W-1];
    assign target        = hit ? {l_entry.target, 2'b00} : '0;

    // Update path
    assign u_idx   = update_pc[IDX_W+1:2];
    assign u_tag   = TAG_FIELD_W'(update_pc[PC_W-1:IDX_W+2]);
    assign u_entry = tbl[u_idx];
    assign u_hit   = u_entry.valid && (u_entry.tag == u_tag);

    sat_counter #(
        .CTR_W(CTR_W)
    ) u_sat_counter (
        .value     (u_entry.ctr[CTR_W-1:0]),
        .up        (update_taken),
        .next_value(ctr_next)
    );

    always_comb begin
        alloc_entry        = '0;
        alloc_entry.valid  = 1'b1;
        alloc_entry.tag    = u_tag;
        alloc_entry.ctr    = CTR_FIELD_W'(CTR_INIT);
        alloc_entry.target = update_target[PC_W-1:2];
    end

    // Falling-edge table write; keeps the existing table's write-edge timing.
    always_ff @(negedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
                tbl[i].ctr   <= '0;
            end
        end else if (update_en) begin
            if (u_hit) begin
                // A hit entry stays valid even when its counter reaches 0.
                tbl[u_idx].ctr <= CTR_FIELD_W'(ctr_next);
                if (update_taken) begin
                    tbl[u_idx].target <= update_target[PC_W-1:2];
                end
            end else if (update_taken) begin
                // Allocate only on taken; not-taken misses leave the table alone.
                tbl[u_idx] <= alloc_entry;
            end
        end
    end

    // Low address bits and the zero-extended field tops are intentionally unread.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0],
                           l_entry.ctr, u_entry.ctr, u_entry.target};

    logic [TAG_W-1:0] unused_tag_w;
    assign unused_tag_w = lookup_pc[PC_W-1:IDX_W+2];

endmodule
